// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared types and constants for the skid-register pipeline stage.
//   state_t : occupancy state of the stage (EMPTY / BUSY / FULL)
//   OCC_W   : width of the occupancy count output (counts 0..2)
package pipe_pkg;

  // Two-bit state encoding; 2'b11 is never entered and is treated as
  // an illegal value that recovers to EMPTY.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_t;

  localparam int OCC_W = 2;

endpackage

// File: rtl/reg_wen.sv
// reg_wen
// WIDTH-bit register with write enable and synchronous active-high reset.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, loads RESET_VAL
//   wen  - write enable; q takes d on the next rising edge when high
//   d    - write data
//   q    - registered value
module reg_wen #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset wins over a write; otherwise hold unless enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (wen) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
// Two-entry valid/ready pipeline register with a skid slot. The main
// register always drives out_data; the skid register catches the word
// accepted while downstream is stalled, so in_ready depends only on the
// registered state and never combinationally on out_ready.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset (empties stage, data = RESET_VAL)
//   flush      - synchronous flush; discards held entries and the offered input
//   in_valid   - upstream word available
//   in_ready   - stage can accept a word this cycle
//   in_data    - upstream payload
//   out_valid  - out_data holds a valid entry
//   out_ready  - downstream accepts out_data this cycle
//   out_data   - oldest held entry
//   occupancy  - number of held entries (0..2)
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  state_t           state_q;
  state_t           state_d;
  logic             in_fire;
  logic             out_fire;
  logic             main_wen;
  logic             skid_wen;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  // Handshake outputs are pure decodes of the state register.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

  // Transfers are suppressed during flush and reset so that neither
  // register is written and no word is counted as accepted or delivered.
  assign in_fire  = in_valid  & in_ready  & ~flush & ~rst;
  assign out_fire = out_valid & out_ready & ~flush & ~rst;

  // Occupancy follows the state; the illegal encoding reports zero.
  always_comb begin
    occupancy = '0;
    case (state_q)
      EMPTY:   occupancy = 2'd0;
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and register write-enable decode. The main register is
  // loaded from in_data except when promoting the skid entry out of FULL.
  always_comb begin
    state_d  = state_q;
    main_wen = 1'b0;
    skid_wen = 1'b0;
    main_d   = in_data;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_wen = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_wen = 1'b1;
        end else if (in_fire) begin
          skid_wen = 1'b1;
          state_d  = FULL;
        end else if (out_fire) begin
          state_d  = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_wen = 1'b1;
          main_d   = skid_q;
          state_d  = BUSY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    // Flush empties the stage; the fire gating already blocks any write.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  reg_wen #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .wen (main_wen),
    .d   (main_d),
    .q   (main_q)
  );

  reg_wen #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .wen (skid_wen),
    .d   (in_data),
    .q   (skid_q)
  );

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 16: data path width in bits; legal range is 1 to 64.
REQ-002 Parameter RESET_VAL, default 0: WIDTH-bit value loaded into both data registers on reset.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port flush, input, 1: synchronous pipeline flush; discards all held entries.
REQ-006 Port in_valid, input, 1: upstream presents in_data.
REQ-007 Port in_ready, output, 1: block can accept in_data this cycle.
REQ-008 Port in_data, input, WIDTH: upstream payload.
REQ-009 Port out_valid, output, 1: out_data holds a valid entry.
REQ-010 Port out_ready, input, 1: downstream accepts out_data this cycle.
REQ-011 Port out_data, output, WIDTH: oldest held entry.
REQ-012 Port occupancy, output, 2: number of held entries, 0 to 2.

Function
REQ-013 Storage: main register (drives out_data) plus skid register; two entries maximum.
REQ-014 States: EMPTY (occupancy 0), BUSY (1, entry in main), FULL (2, oldest in main, newest in skid).
REQ-015 in_ready = (state != FULL), decoded from the state register only; no combinational path from out_ready.
REQ-016 out_valid = (state != EMPTY); out_data = main register; occupancy = 0/1/2 per state.
REQ-017 in_fire = in_valid & in_ready & !flush & !rst; out_fire = out_valid & out_ready & !flush & !rst.
REQ-018 EMPTY: in_fire -> main <= in_data, go BUSY; otherwise stay EMPTY.
REQ-019 BUSY: in_fire & out_fire -> main <= in_data, stay BUSY.
REQ-020 BUSY: in_fire & !out_fire -> skid <= in_data, go FULL.
REQ-021 BUSY: !in_fire & out_fire -> go EMPTY; main is not modified.
REQ-022 BUSY: neither fires -> hold.
REQ-023 FULL: out_fire -> main <= skid, go BUSY; no input is accepted in FULL.
REQ-024 Latency: an accepted word appears on out_data one cycle after in_fire when the block is EMPTY or is BUSY with out_fire.
REQ-025 Ordering: entries leave strictly in acceptance order; no word is duplicated or dropped except by flush or rst.
REQ-026 Priority is rst > flush > normal operation.
REQ-027 Flush: next state is EMPTY; an input offered in the flush cycle is discarded even though in_ready may be high; data registers keep their values.
REQ-028 out_data is stable while out_valid=1 and out_ready=0.
REQ-029 Throughput: sustained in_valid=out_ready=1 yields one word per cycle with no bubbles.

Reset
REQ-030 On rst: state EMPTY and main = skid = RESET_VAL.
REQ-031 Outputs in the cycle after rst: out_valid=0, occupancy=0, in_ready=1, out_data=RESET_VAL.
REQ-032 rst mid-operation discards all entries regardless of in_valid, out_ready or flush.

Structure
REQ-033 Shared package pipe_pkg holds: the state typedef (EMPTY=2'b00, BUSY=2'b01, FULL=2'b10) and the occupancy width constant.
REQ-034 Sub-module reg_wen (parameter WIDTH, RESET_VAL; ports clk, rst, wen, d, q) is instantiated twice, for main and for skid.
REQ-035 The state register is a 2-bit register in pipe_skid_reg; encoding 2'b11 is illegal and SHALL recover to EMPTY.

Verification
REQ-036 Reset, then in_valid=1, in_data=16'h00A5, out_ready=1 -> next cycle out_valid=1, out_data=16'h00A5, occupancy=1.
REQ-037 out_ready=0; accept 16'h0001 then 16'h0002 -> occupancy=2, in_ready=0; raise out_ready -> out_data 16'h0001 then 16'h0002.
REQ-038 Stream 16'h0010 to 16'h001F with out_ready=1 throughout -> 16 consecutive outputs in order, no bubbles.
REQ-039 Block FULL, assert flush with in_valid=1 and in_data=16'hBEEF -> next cycle occupancy=0, out_valid=0, 16'hBEEF never emitted.
REQ-040 Block FULL, assert rst -> next cycle out_data=RESET_VAL, in_ready=1, occupancy=0.
REQ-041 WIDTH=1 and WIDTH=64 builds; random in_valid/out_ready over 10k cycles -> scoreboard shows no loss, duplication or reorder.
